// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// helpers for request legality, alignment and store byte-lane selection.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_WAIT,
        ST_RMW_MERGE,
        ST_RESP
    } lsu_state_e;

    function automatic logic [3:0] store_byte_mask(input logic [2:0] funct3,
                                                   input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (funct3)
            F3_B:    mask = 4'b0001 << addr_lo;
            F3_H:    mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        if (is_store)
            return funct3 inside {F3_B, F3_H, F3_W};
        return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        return ((funct3 == F3_W) && (addr_lo != 2'b00)) ||
               (((funct3 == F3_H) || (funct3 == F3_HU)) && addr_lo[0]);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of the pipeline request/response signals and the word-wide memory
// port; master is the pipeline+memory side, slave is the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_r_enable;
    logic        mem_w_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_re_data;

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_re_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_r_enable, mem_w_enable, mem_address, mem_wr_data
    );

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_re_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_r_enable, mem_w_enable, mem_address, mem_wr_data
    );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational extraction of the addressed byte/halfword from a memory word,
// followed by sign or zero extension according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'h000000, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'h0000, w_half};
            default: o_data = i_word;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: RV32I loads/stores onto a word-wide memory with
// read-modify-write for SB/SH. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus
);
    lsu_state_e  r_state;
    lsu_state_e  w_state_next;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [15:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_req_err;
    logic        w_is_sw;
    logic [31:0] w_req_addr;
    logic [31:0] w_addr_sel;
    logic [31:0] w_load_data;
    logic [31:0] w_store_lanes;
    logic [31:0] w_merged;
    logic [3:0]  w_mask;

    assign w_accept = rst_n && bus.req_valid && (r_state == ST_IDLE);
    assign w_is_sw  = bus.req_is_store && (bus.req_funct3 == F3_W);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_req_err = !funct3_legal(bus.req_is_store, bus.req_funct3) ||
                       is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
    assign w_req_err = !funct3_legal(bus.req_is_store, bus.req_funct3);
`endif

    // Word and halfword accesses are aligned down; misaligned ones only reach
    // the memory when trapping is disabled.
    always_comb begin
        w_req_addr = bus.req_addr;
        case (bus.req_funct3)
            F3_W:        w_req_addr[1:0] = 2'b00;
            F3_H, F3_HU: w_req_addr[0]   = 1'b0;
            default:     ;
        endcase
    end

    lsu_load_align u_load_align (
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr[1:0]),
        .i_word    (bus.mem_re_data),
        .o_data    (w_load_data)
    );

    assign w_mask        = store_byte_mask(r_funct3, r_addr[1:0]);
    assign w_store_lanes = (r_funct3 == F3_B) ? {4{r_wdata[7:0]}} : {2{r_wdata}};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge_lane
            assign w_merged[8*gi +: 8] = w_mask[gi] ? w_store_lanes[8*gi +: 8]
                                                    : bus.mem_re_data[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        w_state_next     = r_state;
        w_addr_sel       = '0;
        bus.req_ready    = 1'b0;
        bus.resp_valid   = 1'b0;
        bus.mem_r_enable = 1'b0;
        bus.mem_w_enable = 1'b0;
        bus.mem_wr_data  = '0;
        case (r_state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (w_accept) begin
                    w_state_next = ST_RESP;
                    if (!w_req_err) begin
                        w_addr_sel = w_req_addr;
                        if (w_is_sw) begin
                            bus.mem_w_enable = 1'b1;
                            bus.mem_wr_data  = bus.req_wdata;
                        end else begin
                            bus.mem_r_enable = 1'b1;
                            w_state_next = bus.req_is_store ? ST_RMW_MERGE : ST_LOAD_WAIT;
                        end
                    end
                end
            end
            ST_LOAD_WAIT: w_state_next = ST_RESP;
            ST_RMW_MERGE: begin
                w_state_next = ST_RESP;
                // Reset during the merge cycle must suppress the pending write.
                if (rst_n) begin
                    bus.mem_w_enable = 1'b1;
                    bus.mem_wr_data  = w_merged;
                    w_addr_sel       = r_addr;
                end
            end
            ST_RESP: begin
                bus.resp_valid = rst_n;
                w_state_next   = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    generate
        if (MEM_WORDS > 1) begin : g_addr_word
            assign bus.mem_address = {2'b00, w_addr_sel[31:2]};
        end else begin : g_addr_single
            assign bus.mem_address = '0;
        end
    endgenerate

    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_funct3 <= bus.req_funct3;
                r_addr   <= w_req_addr;
                r_wdata  <= bus.req_wdata[15:0];
                if (w_req_err || w_is_sw) begin
                    r_rdata <= '0;
                    r_err   <= w_req_err;
                end
            end
            if (r_state == ST_LOAD_WAIT) begin
                r_rdata <= w_load_data;
                r_err   <= 1'b0;
            end
            if (r_state == ST_RMW_MERGE) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomised scoreboard bench for load_store_unit against a byte-level memory
// model; honours LSU_MISALIGN_TRAP_EN in the reference model.
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc_cyc;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   txn_id = 0;
    exp_t exp_q[$];
    logic [31:0] mem [0:31];
    logic [7:0]  ref_bytes [0:127];

    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit #(.MEM_WORDS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Word memory: whole-word writes, one-cycle registered read.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
        end else if (bus.mem_w_enable) begin
            mem[bus.mem_address[4:0]] <= bus.mem_wr_data;
        end
        if (bus.mem_r_enable) bus.mem_re_data <= mem[bus.mem_address[4:0]];
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference: access size from funct3, natural alignment, byte-array memory.
    task automatic model_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] rd, output logic err,
                            output int lat, output int word_idx);
        int size = 0;
        logic sext = 1'b0;
        int base;
        if (st) begin
            case (f3)
                3'd0: size = 1;
                3'd1: size = 2;
                3'd2: size = 4;
                default: size = 0;
            endcase
        end else begin
            case (f3)
                3'd0: begin size = 1; sext = 1'b1; end
                3'd1: begin size = 2; sext = 1'b1; end
                3'd2: size = 4;
                3'd4: size = 1;
                3'd5: size = 2;
                default: size = 0;
            endcase
        end
        err = (size == 0);
`ifdef LSU_MISALIGN_TRAP_EN
        if (!err && (int'(a[6:0]) % size) != 0) err = 1'b1;
`endif
        rd = '0;
        lat = 1;
        word_idx = int'(a[6:2]);
        if (!err) begin
            base = int'(a[6:0]) - (int'(a[6:0]) % size);
            if (st) begin
                for (int k = 0; k < size; k++) ref_bytes[base + k] = wd[8*k +: 8];
                lat = (size == 4) ? 1 : 2;
            end else begin
                for (int k = 0; k < size; k++) rd[8*k +: 8] = ref_bytes[base + k];
                if (sext && rd[8*size - 1])
                    for (int k = size; k < 4; k++) rd[8*k +: 8] = 8'hFF;
                lat = 2;
            end
        end
    endtask

    // Entered and left at a negedge. apply=0 issues the request without
    // touching the model or expecting a response.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic apply);
        exp_t e;
        int waited = 0;
        int widx;
        while (!bus.req_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 20) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: req_ready still %b after %0d cycles, required 1",
                         bus.req_ready, waited);
                return;
            end
        end
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        if (apply) begin
            model_op(st, f3, a, wd, e.rdata, e.err, e.lat, widx);
            e.acc_cyc = cyc;
            e.id = txn_id++;
            exp_q.push_back(e);
            #1;
            checks++;
            if (e.err) begin
                if (bus.mem_r_enable || bus.mem_w_enable) begin
                    errors++;
                    $display("FAIL err_no_mem txn %0d: r_en=%b w_en=%b, required 0/0",
                             e.id, bus.mem_r_enable, bus.mem_w_enable);
                end
            end else if (st && f3 == F3_W) begin
                if (!bus.mem_w_enable || bus.mem_r_enable || bus.mem_address != 32'(widx) ||
                    bus.mem_wr_data != wd) begin
                    errors++;
                    $display("FAIL sw_issue txn %0d: w_en=%b r_en=%b addr=%0d data=%h, required 1/0/%0d/%h",
                             e.id, bus.mem_w_enable, bus.mem_r_enable, bus.mem_address,
                             bus.mem_wr_data, widx, wd);
                end
            end else begin
                if (!bus.mem_r_enable || bus.mem_w_enable || bus.mem_address != 32'(widx)) begin
                    errors++;
                    $display("FAIL rd_issue txn %0d: r_en=%b w_en=%b addr=%0d, required 1/0/%0d",
                             e.id, bus.mem_r_enable, bus.mem_w_enable, bus.mem_address, widx);
                end
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever a response is presented.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (bus.mem_r_enable || bus.mem_w_enable) begin
            checks++;
            if (bus.mem_r_enable && bus.mem_w_enable) begin
                errors++;
                $display("FAIL mem_enables: r_en=1 w_en=1 at cycle %0d, required exclusive", cyc);
            end
        end
        if (bus.resp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: resp_valid=1 rdata=%h err=%b at cycle %0d, required no response",
                         bus.resp_rdata, bus.resp_err, cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.resp_rdata !== e.rdata || bus.resp_err !== e.err || (cyc - e.acc_cyc) != e.lat) begin
                    errors++;
                    $display("FAIL resp txn %0d: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                             e.id, bus.resp_rdata, bus.resp_err, cyc - e.acc_cyc, e.rdata, e.err, e.lat);
                end else begin
                    $display("txn %0d: rdata=%h err=%b lat=%0d", e.id, bus.resp_rdata, bus.resp_err, e.lat);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = '0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        for (int i = 0; i < 32; i++) begin
            ref_bytes[4*i]     = 8'(i);
            ref_bytes[4*i + 1] = 8'h00;
            ref_bytes[4*i + 2] = 8'h00;
            ref_bytes[4*i + 3] = 8'h00;
        end
        repeat (3) @(negedge clk);
        preload = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 ||
            bus.resp_err !== 1'b0 || bus.mem_r_enable !== 1'b0 || bus.mem_w_enable !== 1'b0 ||
            bus.mem_address !== 32'h0 || bus.mem_wr_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b rv=%b rd=%h err=%b re=%b we=%b addr=%h wd=%h, required 1 0 0 0 0 0 0 0",
                     bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err,
                     bus.mem_r_enable, bus.mem_w_enable, bus.mem_address, bus.mem_wr_data);
        end

        issue(1'b0, F3_W,  32'h08, 32'h0, 1'b1);
        issue(1'b1, F3_B,  32'h11, 32'h000000AB, 1'b1);
        issue(1'b0, F3_W,  32'h10, 32'h0, 1'b1);
        issue(1'b1, F3_W,  32'h10, 32'h80FF7F12, 1'b1);
        issue(1'b0, F3_B,  32'h12, 32'h0, 1'b1);
        issue(1'b0, F3_BU, 32'h12, 32'h0, 1'b1);
        issue(1'b0, F3_H,  32'h12, 32'h0, 1'b1);
        issue(1'b0, F3_HU, 32'h10, 32'h0, 1'b1);
        issue(1'b0, F3_W,  32'h06, 32'h0, 1'b1);
        issue(1'b0, 3'b011, 32'h00, 32'h0, 1'b1);
        issue(1'b1, 3'b011, 32'h04, 32'h12345678, 1'b1);
        issue(1'b1, F3_H,  32'h3A, 32'hBEEF, 1'b1);
        issue(1'b0, F3_W,  32'h38, 32'h0, 1'b1);

        // Reset during the RMW merge cycle: the write must be dropped.
        issue(1'b1, F3_H, 32'h20, 32'h00005555, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_w_enable !== 1'b0 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rmw: w_en=%b resp_valid=%b, required 0 0",
                     bus.mem_w_enable, bus.resp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b, required 1", bus.req_ready);
        end
        @(negedge clk);
        issue(1'b0, F3_W, 32'h20, 32'h0, 1'b1);

        for (int n = 0; n < 300; n++) begin
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  32'($urandom_range(0, 127)), $urandom, 1'b1);
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL resp_timeout: %0d responses outstanding, required 0", exp_q.size());
        end

        for (int i = 0; i < 32; i++) begin
            logic [31:0] w;
            w = {ref_bytes[4*i + 3], ref_bytes[4*i + 2], ref_bytes[4*i + 1], ref_bytes[4*i]};
            checks++;
            if (mem[i] !== w) begin
                errors++;
                $display("FAIL mem_word %0d: got %h, required %h", i, mem[i], w);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage initiator for the 32-word data memory. Accepts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) from the pipeline and translates them into word-wide accesses on the memory's r_enable/w_enable/address/wr_data/re_data port. Handles byte and halfword selection, sign/zero extension, and read-modify-write for sub-word stores. The memory itself supports only whole-word writes with a one-cycle registered read.

## Interface
Parameters:
- MEM_WORDS, 32: memory depth in words; word index width is clog2(MEM_WORDS).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  pipeline request present.
- req_ready  out  1  high only in IDLE; a request transfers when req_valid && req_ready.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/halfword used for SB/SH.
- resp_valid  out  1  one-cycle pulse; operation complete.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal funct3; qualified by resp_valid.
- mem_r_enable  out  1  to memory r_enable.
- mem_w_enable  out  1  to memory w_enable.
- mem_address  out  32  word index, {2'b00, req_addr[31:2]} (memory is word-indexed).
- mem_wr_data  out  32  to memory wr_data.
- mem_re_data  in  32  from memory re_data; valid the cycle after mem_r_enable.

## Operation
- FSM states: IDLE, LOAD_WAIT, RMW_MERGE, RESP.
- Request fields are captured into registers on acceptance. Memory-side outputs are combinational from the state and the captured or live request.
- IDLE, accepted LW/LH/LHU/LB/LBU: assert mem_r_enable; next state LOAD_WAIT.
- IDLE, accepted SW: assert mem_w_enable with mem_wr_data = req_wdata; next state RESP.
- IDLE, accepted SB/SH: assert mem_r_enable; next state RMW_MERGE.
- LOAD_WAIT: select byte (addr[1:0]) or halfword (addr[1]) from mem_re_data, then sign- or zero-extend. Register the result into resp_rdata; next state RESP.
- RMW_MERGE: mem_wr_data = mem_re_data with the addressed byte/halfword replaced by req_wdata[7:0]/[15:0]. Assert mem_w_enable; next state RESP.
- RESP: resp_valid = 1; next state IDLE. resp_rdata holds until the next response.
- Error cases: illegal funct3 (load 011/110/111; store other than 000/001/010) or a misaligned access (see Configuration). No memory enable is asserted; next state RESP with resp_err = 1 and resp_rdata = 0.
- Never assert mem_r_enable and mem_w_enable in the same cycle.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_r_enable 0, mem_w_enable 0, mem_address 0, mem_wr_data 0.
- Acceptance at cycle 0 gives resp_valid at:
  - loads: cycle 2;
  - SW and errors: cycle 1;
  - SB/SH: cycle 2, with the write occurring at the end of cycle 1.
- req_ready is low from cycle 1 until the cycle after RESP, giving one outstanding request.
- Back-to-back throughput: one operation per 2 cycles (SW/error) or 3 cycles (load/RMW).
- Reset asserted mid-operation: return to IDLE on that edge and drop any pending RMW write. The memory contents for an already-issued write are unaffected. No response is emitted.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - LW with addr[1:0] != 0, or LH/LHU/SH with addr[0] != 0, is an error (resp_err = 1) with no memory access.
- LSU_MISALIGN_TRAP_EN undefined:
  - the offending low address bits are forced to 0 (word/halfword aligned down) and the access proceeds;
  - resp_err is raised only for illegal funct3.

## Structure
- Shared package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the FSM state enum;
  - a function computing the store byte-lane mask from funct3 and addr[1:0].
- One sub-module, lsu_load_align: purely combinational byte/halfword extraction and extension, instanced in the LOAD_WAIT path.

## Test plan
Memory is preloaded with word i = i.
- LW addr 0x08 -> resp_valid at cycle 2, resp_rdata 0x00000002, err 0.
- SW 0x80FF7F12 to 0x10, then:
  - LB 0x12 -> 0xFFFFFFFF;
  - LBU 0x12 -> 0x000000FF;
  - LH 0x12 -> 0xFFFF80FF;
  - LHU 0x10 -> 0x00007F12.
- SB 0xAB to 0x11 (word 4 = 0x00000004) -> mem read at cycle 0, write 0x0000AB04 at cycle 1, resp_valid at cycle 2. A following LW 0x10 returns 0x0000AB04.
- LW 0x06:
  - with LSU_MISALIGN_TRAP_EN -> no mem enable, resp_valid at cycle 1, err 1, rdata 0;
  - without it -> reads word 1, rdata 0x00000001.
- Load with funct3 011 -> err 1, no mem enables. SB with funct3 011 -> err 1.
- Accept SH, then pull rst_n low at cycle 1 -> no mem_w_enable at cycle 1, no resp_valid, req_ready 1 after reset, word unchanged.
